// File: rtl/axil_cmd_master.sv
// AXI4-Lite command master: turns one local command at a time into a single
// AXI4-Lite read or write and returns one response for it. A sticky timeout
// flag reports a transaction that has been waiting too long without aborting it.
module axil_cmd_master #(
   parameter int TIMEOUT = 1024
) (
   input  logic        M_AXI_ACLK,
   input  logic        M_AXI_ARESET,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic        CMD_WRITE,
   input  logic [31:0] CMD_ADDR,
   input  logic [31:0] CMD_WDATA,
   input  logic [3:0]  CMD_WSTRB,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic        RSP_WRITE,
   output logic [31:0] RSP_RDATA,
   output logic [1:0]  RSP_RESP,
   output logic        TIMEOUT_FLAG,
   output logic [31:0] M_AXI_AWADDR,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [31:0] M_AXI_ARADDR,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   // Counter is sized to hold TIMEOUT; TIMEOUT = 0 leaves it pinned at its
   // saturation value so it never counts and the flag never sets.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WREQ  = 3'd1,
      WRESP = 3'd2,
      RREQ  = 3'd3,
      RRESP = 3'd4,
      RSP   = 3'd5
   } state_t;

   state_t           state;
   logic             cmd_write_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic             aw_done;
   logic             w_done;
   logic [CNT_W-1:0] to_cnt;

   logic aw_hs;
   logic w_hs;
   logic aw_fin;
   logic w_fin;
   logic in_wait;
   logic cmd_acc;

   assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
   assign w_hs    = M_AXI_WVALID & M_AXI_WREADY;
   assign aw_fin  = aw_done | aw_hs;
   assign w_fin   = w_done | w_hs;
   assign in_wait = (state == WREQ) || (state == WRESP) ||
                    (state == RREQ) || (state == RRESP);
   assign cmd_acc = (state == IDLE) && CMD_VALID;

   // Accept only in IDLE; decoded from registered state, so no input-to-output path.
   assign CMD_READY    = (state == IDLE);
   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = wdata_q;
   assign M_AXI_WSTRB  = wstrb_q;

   // Transaction FSM with registered channel handshakes and response capture.
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state         <= IDLE;
         cmd_write_q   <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         RSP_VALID     <= 1'b0;
         RSP_WRITE     <= 1'b0;
         RSP_RDATA     <= '0;
         RSP_RESP      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (CMD_VALID) begin
                  cmd_write_q <= CMD_WRITE;
                  addr_q      <= CMD_ADDR;
                  wdata_q     <= CMD_WDATA;
                  wstrb_q     <= CMD_WSTRB;
                  if (CMD_WRITE) begin
                     state         <= WREQ;
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                     aw_done       <= 1'b0;
                     w_done        <= 1'b0;
                  end else begin
                     state         <= RREQ;
                     M_AXI_ARVALID <= 1'b1;
                  end
               end
            end
            WREQ: begin
               // AW and W complete independently, in either order or together.
               if (aw_hs) begin
                  M_AXI_AWVALID <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  M_AXI_WVALID <= 1'b0;
                  w_done       <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  state        <= WRESP;
                  M_AXI_BREADY <= 1'b1;
               end
            end
            WRESP: begin
               if (M_AXI_BVALID) begin
                  M_AXI_BREADY <= 1'b0;
                  RSP_VALID    <= 1'b1;
                  RSP_WRITE    <= cmd_write_q;
                  RSP_RDATA    <= '0;
                  RSP_RESP     <= M_AXI_BRESP;
                  state        <= RSP;
               end
            end
            RREQ: begin
               if (M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  state         <= RRESP;
               end
            end
            RRESP: begin
               if (M_AXI_RVALID) begin
                  M_AXI_RREADY <= 1'b0;
                  RSP_VALID    <= 1'b1;
                  RSP_WRITE    <= cmd_write_q;
                  RSP_RDATA    <= M_AXI_RDATA;
                  RSP_RESP     <= M_AXI_RRESP;
                  state        <= RSP;
               end
            end
            RSP: begin
               if (RSP_READY) begin
                  RSP_VALID <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Wait-state cycle counter with sticky flag; both restart on command acceptance.
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         to_cnt       <= '0;
         TIMEOUT_FLAG <= 1'b0;
      end else if (cmd_acc) begin
         to_cnt       <= '0;
         TIMEOUT_FLAG <= 1'b0;
      end else if (in_wait && (to_cnt != CNT_MAX)) begin
         to_cnt <= to_cnt + 1'b1;
         if ((to_cnt + 1'b1) == CNT_MAX) begin
            TIMEOUT_FLAG <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small AXI-Lite memory slave model.
module tb_axil_cmd_master;

   logic        M_AXI_ACLK = 1'b0;
   logic        M_AXI_ARESET;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic        CMD_WRITE;
   logic [31:0] CMD_ADDR;
   logic [31:0] CMD_WDATA;
   logic [3:0]  CMD_WSTRB;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic        RSP_WRITE;
   logic [31:0] RSP_RDATA;
   logic [1:0]  RSP_RESP;
   logic        TIMEOUT_FLAG;
   logic [31:0] M_AXI_AWADDR;
   logic        M_AXI_AWVALID;
   logic        M_AXI_AWREADY;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_WVALID;
   logic        M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BVALID;
   logic        M_AXI_BREADY;
   logic [31:0] M_AXI_ARADDR;
   logic        M_AXI_ARVALID;
   logic        M_AXI_ARREADY;
   logic [31:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RVALID;
   logic        M_AXI_RREADY;

   // slave knobs
   logic        aw_rdy, w_rdy, ar_rdy, b_hold;
   logic [1:0]  r_resp_cfg;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 M_AXI_ACLK = ~M_AXI_ACLK;

   axil_cmd_master #(.TIMEOUT(8)) dut (
      .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
      .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .TIMEOUT_FLAG(TIMEOUT_FLAG),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   // ---------------- memory slave model ----------------
   logic [31:0] mem [0:1023];
   logic        aw_got, w_got;
   logic [31:0] aw_a, w_d;
   logic [3:0]  w_s;
   int          b_hs_cnt;
   logic        s_aw_hs, s_w_hs;
   logic [31:0] eff_a, eff_d;
   logic [3:0]  eff_s;

   assign M_AXI_AWREADY = aw_rdy;
   assign M_AXI_WREADY  = w_rdy;
   assign M_AXI_ARREADY = ar_rdy;
   assign s_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
   assign s_w_hs  = M_AXI_WVALID & M_AXI_WREADY;
   assign eff_a   = s_aw_hs ? M_AXI_AWADDR : aw_a;
   assign eff_d   = s_w_hs ? M_AXI_WDATA : w_d;
   assign eff_s   = s_w_hs ? M_AXI_WSTRB : w_s;

   always @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
         M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
         M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
      end else begin
         if (s_aw_hs) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; end
         if (s_w_hs) begin w_got <= 1'b1; w_d <= M_AXI_WDATA; w_s <= M_AXI_WSTRB; end
         if ((aw_got | s_aw_hs) && (w_got | s_w_hs) && !b_hold && !M_AXI_BVALID) begin
            for (int i = 0; i < 4; i++)
               if (eff_s[i]) mem[eff_a[11:2]][8*i +: 8] <= eff_d[8*i +: 8];
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= 2'b00;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BVALID <= 1'b0;
            b_hs_cnt <= b_hs_cnt + 1;
         end
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_RVALID <= 1'b1;
            M_AXI_RDATA  <= mem[M_AXI_ARADDR[11:2]];
            M_AXI_RRESP  <= r_resp_cfg;
         end else if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RVALID <= 1'b0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one command with RSP_READY as currently driven; returns at the
   // falling edge of the first cycle showing RSP_VALID (rc = cycle index, -1 if none).
   task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int rc, output logic rw,
                          output logic [31:0] rd, output logic [1:0] rr, output logic f1);
      int guard;
      rc = -1; rw = 1'b0; rd = '0; rr = 2'b00; f1 = 1'b0;
      @(negedge M_AXI_ACLK);
      guard = 0;
      while (!CMD_READY && guard < 50) begin
         @(negedge M_AXI_ACLK);
         guard++;
      end
      CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
      @(posedge M_AXI_ACLK);
      #1 CMD_VALID = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge M_AXI_ACLK);
         if (c == 1) f1 = TIMEOUT_FLAG;
         if (RSP_VALID) begin
            rc = c; rw = RSP_WRITE; rd = RSP_RDATA; rr = RSP_RESP;
            break;
         end
      end
   endtask

   task automatic finish_rsp(input string tag);
      @(negedge M_AXI_ACLK);
      chk({tag, "_cmdrdy_after"}, {31'd0, CMD_READY}, 32'd1);
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge M_AXI_ACLK);
      CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = 4'hF;
      @(posedge M_AXI_ACLK);
      #1 CMD_VALID = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          rc, b0;
      logic        rw, f1, f8, f9, av9;
      logic [31:0] rd;
      logic [1:0]  rr;
      logic        awv [1:8];
      logic        wv  [1:8];
      logic        br  [1:8];

      M_AXI_ARESET = 1'b1;
      CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WSTRB = '0;
      RSP_READY = 1'b1;
      aw_rdy = 1'b1; w_rdy = 1'b1; ar_rdy = 1'b1; b_hold = 1'b0; r_resp_cfg = 2'b00;
      b_hs_cnt = 0;
      repeat (3) @(negedge M_AXI_ACLK);
      chk("rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
      chk("rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
      chk("rst_awvalid",   {31'd0, M_AXI_AWVALID}, 32'd0);
      chk("rst_arvalid",   {31'd0, M_AXI_ARVALID}, 32'd0);
      chk("rst_timeout",   {31'd0, TIMEOUT_FLAG}, 32'd0);
      chk("rst_awaddr",    M_AXI_AWADDR, 32'd0);
      M_AXI_ARESET = 1'b0;

      // write 0x400 <- DEADBEEF, then read it back
      run_cmd(1'b1, 32'h400, 32'hDEADBEEF, 4'hF, rc, rw, rd, rr, f1);
      chk("wr_rsp_cycle", rc, 32'd3);
      chk("wr_rsp_resp", {30'd0, rr}, 32'd0);
      chk("wr_rsp_rdata", rd, 32'd0);
      chk("wr_rsp_write", {31'd0, rw}, 32'd1);
      finish_rsp("wr");
      run_cmd(1'b0, 32'h400, 32'h0, 4'h0, rc, rw, rd, rr, f1);
      chk("rd_rsp_cycle", rc, 32'd3);
      chk("rd_rsp_rdata", rd, 32'hDEADBEEF);
      chk("rd_rsp_resp", {30'd0, rr}, 32'd0);
      chk("rd_rsp_write", {31'd0, rw}, 32'd0);
      finish_rsp("rd");

      // split write: W stalled until cycle 5
      aw_rdy = 1'b1; w_rdy = 1'b0; b0 = b_hs_cnt;
      issue(1'b1, 32'h408, 32'h12345678);
      for (int c = 1; c <= 8; c++) begin
         if (c == 5) w_rdy = 1'b1;
         @(negedge M_AXI_ACLK);
         awv[c] = M_AXI_AWVALID; wv[c] = M_AXI_WVALID; br[c] = M_AXI_BREADY;
         @(posedge M_AXI_ACLK);
         #1;
      end
      chk("split_awv_c1", {31'd0, awv[1]}, 32'd1);
      chk("split_awv_c2", {31'd0, awv[2]}, 32'd0);
      chk("split_wv_c4", {31'd0, wv[4]}, 32'd1);
      chk("split_wv_c5", {31'd0, wv[5]}, 32'd1);
      chk("split_wv_c6", {31'd0, wv[6]}, 32'd0);
      chk("split_br_c5", {31'd0, br[5]}, 32'd0);
      chk("split_br_c6", {31'd0, br[6]}, 32'd1);
      chk("split_b_count", b_hs_cnt - b0, 32'd1);
      run_cmd(1'b0, 32'h408, 32'h0, 4'h0, rc, rw, rd, rr, f1);
      chk("split_readback", rd, 32'h12345678);
      finish_rsp("split");

      // register write/read, response held with RSP_READY low
      run_cmd(1'b1, 32'h004, 32'h000001FF, 4'hF, rc, rw, rd, rr, f1);
      finish_rsp("regwr");
      RSP_READY = 1'b0;
      run_cmd(1'b0, 32'h004, 32'h0, 4'h0, rc, rw, rd, rr, f1);
      chk("reg_rsp_cycle", rc, 32'd3);
      chk("reg_rdata", {23'd0, rd[8:0]}, 32'h1FF);
      for (int k = 0; k < 3; k++) begin
         @(negedge M_AXI_ACLK);
         chk("hold_rsp_valid", {31'd0, RSP_VALID}, 32'd1);
         chk("hold_rsp_rdata", RSP_RDATA, rd);
         chk("hold_cmd_ready", {31'd0, CMD_READY}, 32'd0);
      end
      RSP_READY = 1'b1;
      finish_rsp("hold");

      // timeout: ARREADY stalled
      ar_rdy = 1'b0; f8 = 1'b0; f9 = 1'b0; av9 = 1'b0;
      issue(1'b0, 32'h400, 32'h0);
      for (int c = 1; c <= 9; c++) begin
         @(negedge M_AXI_ACLK);
         if (c == 8) f8 = TIMEOUT_FLAG;
         if (c == 9) begin f9 = TIMEOUT_FLAG; av9 = M_AXI_ARVALID; end
         @(posedge M_AXI_ACLK);
         #1;
      end
      ar_rdy = 1'b1;
      rc = -1; rd = '0;
      for (int c = 10; c < 40; c++) begin
         @(negedge M_AXI_ACLK);
         if (RSP_VALID) begin rc = c; rd = RSP_RDATA; break; end
      end
      chk("to_flag_c8", {31'd0, f8}, 32'd0);
      chk("to_flag_c9", {31'd0, f9}, 32'd1);
      chk("to_arvalid_c9", {31'd0, av9}, 32'd1);
      chk("to_rsp_cycle", rc, 32'd12);
      chk("to_rdata", rd, 32'hDEADBEEF);
      chk("to_flag_sticky", {31'd0, TIMEOUT_FLAG}, 32'd1);
      finish_rsp("to");
      run_cmd(1'b0, 32'h400, 32'h0, 4'h0, rc, rw, rd, rr, f1);
      chk("to_flag_cleared", {31'd0, f1}, 32'd0);
      chk("to_next_rdata", rd, 32'hDEADBEEF);
      finish_rsp("to_next");

      // reset mid-transaction in WRESP with BVALID low, after timeout set
      b_hold = 1'b1;
      issue(1'b1, 32'h00C, 32'h00000055);
      repeat (9) begin
         @(posedge M_AXI_ACLK);
         #1;
      end
      chk("pre_rst_bready", {31'd0, M_AXI_BREADY}, 32'd1);
      chk("pre_rst_timeout", {31'd0, TIMEOUT_FLAG}, 32'd1);
      M_AXI_ARESET = 1'b1;
      #1;
      chk("arst_bready", {31'd0, M_AXI_BREADY}, 32'd0);
      chk("arst_awvalid", {31'd0, M_AXI_AWVALID}, 32'd0);
      chk("arst_wvalid", {31'd0, M_AXI_WVALID}, 32'd0);
      chk("arst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
      chk("arst_timeout", {31'd0, TIMEOUT_FLAG}, 32'd0);
      chk("arst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
      @(negedge M_AXI_ACLK);
      M_AXI_ARESET = 1'b0;
      b_hold = 1'b0;
      run_cmd(1'b0, 32'h400, 32'h0, 4'h0, rc, rw, rd, rr, f1);
      chk("post_rst_cycle", rc, 32'd3);
      chk("post_rst_rdata", rd, 32'hDEADBEEF);
      finish_rsp("post_rst");

      // error response forwarded
      r_resp_cfg = 2'b10;
      run_cmd(1'b0, 32'h400, 32'h0, 4'h0, rc, rw, rd, rr, f1);
      chk("err_resp", {30'd0, rr}, 32'd2);
      chk("err_write", {31'd0, rw}, 32'd0);
      chk("err_rdata", rd, 32'hDEADBEEF);
      r_resp_cfg = 2'b00;
      finish_rsp("err");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
